ifid_skid_reg: RTL and testbench

- Parametrised IF/ID pipeline register for the pipelined processor.
- Carries instruction and PC from fetch to decode through a 2-entry elastic (skid) buffer with a valid/ready handshake on both sides.
- Supports decode stalls without a combinational ready path back to fetch, and a branch/jump flush that inserts a NOP bubble.
- Counts valid instructions discarded by flushes.

---
 rtl/ifid_skid_reg.sv | 119 +++++++++++
 tb/tb_ifid_skid_reg.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register built as a 2-entry skid buffer.
// in_ready depends only on registered state (and reset), so a decode stall
// never reaches fetch through a combinational path. A flush empties the stage,
// puts a NOP on the outputs, and adds the number of valid instructions it threw
// away to a saturating counter.
module ifid_skid_reg #(
  parameter int INS_WIDTH = 8,
  parameter int PC_WIDTH  = 8,
  parameter logic [INS_WIDTH-1:0] NOP_CODE = '0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INS_WIDTH-1:0] ins_in,
  input  logic [PC_WIDTH-1:0]  pc_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INS_WIDTH-1:0] instruction_code,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] flushed_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [INS_WIDTH-1:0] ins;
    logic [PC_WIDTH-1:0]  pc;
  } entry_t;

  localparam entry_t BUBBLE = '{ins: NOP_CODE, pc: '0};
  localparam logic [CNT_WIDTH+1:0] CNT_MAX = {2'b00, {CNT_WIDTH{1'b1}}};

  state_t               state, state_nxt;
  entry_t               main_q, main_nxt;
  entry_t               skid_q, skid_nxt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;

  entry_t               in_e;
  logic                 accept, consume;
  logic [2:0]           discard;
  logic [CNT_WIDTH+1:0] cnt_sum;

  assign in_e             = '{ins: ins_in, pc: pc_in};
  assign in_ready         = (state != FULL) & ~reset;
  assign out_valid        = (state != EMPTY);
  assign occupancy        = state;
  assign instruction_code = main_q.ins;
  assign pc_out           = main_q.pc;
  assign flushed_count    = cnt_q;
  assign accept           = in_valid & in_ready;
  assign consume          = out_valid & out_ready;

  // Valid entries a flush throws away: those held, less one delivered this
  // cycle, plus one accepted this cycle. The counter saturates instead of wrapping.
  always_comb begin
    discard = {1'b0, occupancy} - {2'b00, consume} + {2'b00, accept};
    cnt_sum = {2'b00, cnt_q} + {{(CNT_WIDTH-1){1'b0}}, discard};
    cnt_nxt = cnt_q;
    if (flush)
      cnt_nxt = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_WIDTH-1:0] : cnt_sum[CNT_WIDTH-1:0];
  end

  // Next state and datapath; flush overrides every handshake.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          main_nxt  = in_e;
          state_nxt = HALF;
        end
        HALF: begin
          if (accept && consume) begin
            main_nxt = in_e;
          end else if (accept) begin
            skid_nxt  = in_e;
            state_nxt = FULL;
          end else if (consume) begin
            main_nxt  = BUBBLE;
            state_nxt = EMPTY;
          end
        end
        FULL: if (consume) begin
          main_nxt  = skid_q;
          state_nxt = HALF;
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = BUBBLE;
        end
      endcase
    end
  end

  // State, main/skid entries and discard counter; reset clears at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      cnt_q  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifid_skid_reg.sv
// Directed bench for ifid_skid_reg, built with CNT_WIDTH=2 so that
// counter saturation can be reached in a handful of flushes.
module tb_ifid_skid_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0] ins_in, pc_in, instruction_code, pc_out;
  logic [1:0] occupancy;
  logic [1:0] flushed_count;

  int n_chk  = 0;
  int n_fail = 0;

  ifid_skid_reg #(.INS_WIDTH(8), .PC_WIDTH(8), .NOP_CODE(8'h00), .CNT_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ins_in(ins_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .instruction_code(instruction_code), .pc_out(pc_out),
    .occupancy(occupancy), .flushed_count(flushed_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] i, input logic [7:0] p);
    in_valid = v;
    ins_in   = i;
    pc_in    = p;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    reset = 1'b0;

    // Idle after reset
    repeat (3) step();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_ins", instruction_code, 8'h00);
    chk("idle_pc", pc_out, 8'h00);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_occ", occupancy, 0);
    chk("idle_cnt", flushed_count, 0);

    // Streaming, one instruction per cycle
    out_ready = 1'b1;
    drive(1'b1, 8'h11, 8'h00); step();
    chk("s1_ins", instruction_code, 8'h11); chk("s1_pc", pc_out, 8'h00);
    chk("s1_occ", occupancy, 1); chk("s1_valid", out_valid, 1);
    drive(1'b1, 8'h22, 8'h01); step();
    chk("s2_ins", instruction_code, 8'h22); chk("s2_pc", pc_out, 8'h01);
    chk("s2_occ", occupancy, 1);
    drive(1'b1, 8'h33, 8'h02); step();
    chk("s3_ins", instruction_code, 8'h33); chk("s3_pc", pc_out, 8'h02);
    chk("s3_occ", occupancy, 1);
    drive(1'b0, 8'h00, 8'h00); step();
    chk("s4_valid", out_valid, 0); chk("s4_ins", instruction_code, 8'h00);
    chk("s4_occ", occupancy, 0);

    // Stall fill, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 8'hA1, 8'h10); step();
    drive(1'b1, 8'hA2, 8'h11); step();
    drive(1'b0, 8'h00, 8'h00);
    chk("f_occ", occupancy, 2); chk("f_in_ready", in_ready, 0);
    chk("f_ins", instruction_code, 8'hA1); chk("f_pc", pc_out, 8'h10);
    step();
    chk("f_hold_ins", instruction_code, 8'hA1); chk("f_hold_pc", pc_out, 8'h10);
    out_ready = 1'b1; step();
    chk("d1_ins", instruction_code, 8'hA2); chk("d1_pc", pc_out, 8'h11);
    chk("d1_in_ready", in_ready, 1); chk("d1_occ", occupancy, 1);
    step();
    chk("d2_valid", out_valid, 0); chk("d2_occ", occupancy, 0);

    // Flush while FULL with an instruction offered (not accepted)
    out_ready = 1'b0;
    drive(1'b1, 8'hB1, 8'h20); step();
    drive(1'b1, 8'hB2, 8'h21); step();
    chk("bf_occ", occupancy, 2);
    drive(1'b1, 8'hB3, 8'h22); flush = 1'b1; step();
    flush = 1'b0; drive(1'b0, 8'h00, 8'h00);
    chk("bf_valid", out_valid, 0); chk("bf_ins", instruction_code, 8'h00);
    chk("bf_pc", pc_out, 8'h00); chk("bf_occ", occupancy, 0);
    chk("bf_cnt", flushed_count, 2); chk("bf_in_ready", in_ready, 1);
    step();
    chk("bf_stay_empty", out_valid, 0);

    // Flush in HALF with simultaneous consume and accept
    drive(1'b1, 8'hC1, 8'h30); step();
    drive(1'b1, 8'hC2, 8'h31); out_ready = 1'b1; flush = 1'b1;
    chk("cf_pre_ins", instruction_code, 8'hC1); chk("cf_pre_valid", out_valid, 1);
    step();
    flush = 1'b0; drive(1'b0, 8'h00, 8'h00); out_ready = 1'b0;
    chk("cf_valid", out_valid, 0); chk("cf_ins", instruction_code, 8'h00);
    chk("cf_occ", occupancy, 0); chk("cf_cnt", flushed_count, 3);
    step();
    chk("cf_no_c2", out_valid, 0);

    // Asynchronous reset between edges
    drive(1'b1, 8'hD1, 8'h40); step();
    drive(1'b0, 8'h00, 8'h00);
    chk("ar_pre_occ", occupancy, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0); chk("ar_ins", instruction_code, 8'h00);
    chk("ar_occ", occupancy, 0); chk("ar_cnt", flushed_count, 0);
    chk("ar_in_ready", in_ready, 0);
    #1 reset = 1'b0;

    // Saturation: four flushes, each discarding one accepted instruction
    out_ready = 1'b0;
    drive(1'b1, 8'hE0, 8'h50); flush = 1'b1;
    step(); chk("sat1", flushed_count, 1);
    step(); chk("sat2", flushed_count, 2);
    step(); chk("sat3", flushed_count, 3);
    step(); chk("sat4", flushed_count, 3);
    chk("sat_valid", out_valid, 0);
    flush = 1'b0; drive(1'b0, 8'h00, 8'h00);
    step();
    chk("sat_hold", flushed_count, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
